// File: rtl/nic_pe_driver.sv
// Processing-element side driver for one ring NIC port: injects a programmed burst of
// packets into the NIC output channel while draining its input channel, both by status polling.
module nic_pe_driver #(
    parameter int PKT_W = 64,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_pkts,
    input  logic [CNT_W-1:0] rx_expect,
    input  logic             vc_sel,
    input  logic             dir_sel,
    input  logic [7:0]       hop_mask,
    input  logic [15:0]      src_id,
    input  logic [31:0]      seed,
    output logic [1:0]       addr,
    output logic [PKT_W-1:0] d_in,
    output logic             nicEN,
    output logic             nicWrEn,
    input  logic [PKT_W-1:0] d_out,
    output logic             rx_valid,
    output logic [PKT_W-1:0] rx_data,
    output logic [CNT_W-1:0] tx_count,
    output logic [CNT_W-1:0] rx_count,
    output logic             busy,
    output logic             done
);

    typedef enum logic [3:0] {
        IDLE,
        TX_POLL,
        TX_CHK,
        TX_WR,
        RX_POLL,
        RX_CHK,
        RX_RD,
        RX_CAP,
        DONE
    } state_t;

    localparam logic [1:0] ADDR_IN_BUF  = 2'b00;
    localparam logic [1:0] ADDR_IN_STAT = 2'b01;
    localparam logic [1:0] ADDR_OUT_BUF = 2'b10;
    localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

    state_t           state, state_n;
    logic [CNT_W-1:0] num_q, rxexp_q, num_n, rxexp_n;
    logic [CNT_W-1:0] tx_n, rx_n;
    logic             vc_q, dir_q;
    logic [7:0]       hop_q;
    logic [15:0]      src_q;
    logic [31:0]      seed_q;
    logic             cfg_load;
    logic [63:0]      pkt;

    logic             req_en, req_wr;
    logic [1:0]       req_addr;
    logic [PKT_W-1:0] req_data;

    assign pkt = {vc_q, dir_q, 6'b0, hop_q, src_q, seed_q + 32'(tx_count)};

    always_comb begin
        state_n  = state;
        tx_n     = tx_count;
        rx_n     = rx_count;
        num_n    = num_q;
        rxexp_n  = rxexp_q;
        cfg_load = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    cfg_load = 1'b1;
                    num_n    = num_pkts;
                    rxexp_n  = rx_expect;
                    tx_n     = '0;
                    rx_n     = '0;
                    state_n  = TX_POLL;
                end
            end
            TX_POLL: state_n = (tx_count == num_q) ? RX_POLL : TX_CHK;
            TX_CHK:  state_n = d_out[0] ? RX_POLL : TX_WR;
            TX_WR: begin
                tx_n    = tx_count + 1'b1;
                state_n = RX_POLL;
            end
            RX_POLL: begin
                if (rx_count == rxexp_q)
                    state_n = (tx_count == num_q) ? DONE : TX_POLL;
                else
                    state_n = RX_CHK;
            end
            RX_CHK: begin
                if (d_out[0])
                    state_n = RX_RD;
                else
                    state_n = (tx_count == num_q) ? RX_POLL : TX_POLL;
            end
            RX_RD:   state_n = RX_CAP;
            RX_CAP: begin
                rx_n    = rx_count + 1'b1;
                state_n = TX_POLL;
            end
            default: state_n = IDLE;
        endcase

        // NIC outputs are registered, so the request for the upcoming state is decided here
        // from its next-cycle counters; the NIC answer then lands in the following state.
        req_en   = 1'b0;
        req_wr   = 1'b0;
        req_addr = ADDR_IN_BUF;
        req_data = '0;
        case (state_n)
            TX_POLL: begin
                if (tx_n != num_n) begin
                    req_en   = 1'b1;
                    req_addr = ADDR_OUT_STAT;
                end
            end
            TX_WR: begin
                req_en   = 1'b1;
                req_wr   = 1'b1;
                req_addr = ADDR_OUT_BUF;
                req_data = PKT_W'(pkt);
            end
            RX_POLL: begin
                if (rx_n != rxexp_n) begin
                    req_en   = 1'b1;
                    req_addr = ADDR_IN_STAT;
                end
            end
            RX_RD: begin
                req_en   = 1'b1;
                req_addr = ADDR_IN_BUF;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tx_count <= '0;
            rx_count <= '0;
            num_q    <= '0;
            rxexp_q  <= '0;
            vc_q     <= 1'b0;
            dir_q    <= 1'b0;
            hop_q    <= '0;
            src_q    <= '0;
            seed_q   <= '0;
        end else begin
            state    <= state_n;
            tx_count <= tx_n;
            rx_count <= rx_n;
            num_q    <= num_n;
            rxexp_q  <= rxexp_n;
            if (cfg_load) begin
                vc_q   <= vc_sel;
                dir_q  <= dir_sel;
                hop_q  <= hop_mask;
                src_q  <= src_id;
                seed_q <= seed;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr     <= ADDR_IN_BUF;
            d_in     <= '0;
            nicEN    <= 1'b0;
            nicWrEn  <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            addr     <= req_addr;
            d_in     <= req_data;
            nicEN    <= req_en;
            nicWrEn  <= req_wr;
            rx_valid <= (state == RX_CAP);
            if (state == RX_CAP)
                rx_data <= d_out;
            busy     <= !((state_n == IDLE) || (state_n == DONE));
            done     <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_nic_pe_driver.sv
// Directed bench for nic_pe_driver with a registered NIC model and queue scoreboards
// for packets written to the output channel and packets drained from the input channel.
module tb_nic_pe_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  num_pkts = '0;
    logic [7:0]  rx_expect = '0;
    logic        vc_sel = 1'b0;
    logic        dir_sel = 1'b0;
    logic [7:0]  hop_mask = '0;
    logic [15:0] src_id = '0;
    logic [31:0] seed = '0;
    logic [1:0]  addr;
    logic [63:0] d_in;
    logic        nicEN;
    logic        nicWrEn;
    logic [63:0] d_out = '0;
    logic        rx_valid;
    logic [63:0] rx_data;
    logic [7:0]  tx_count;
    logic [7:0]  rx_count;
    logic        busy;
    logic        done;

    logic        out_full = 1'b0;
    logic [63:0] nic_in[$];
    logic [63:0] tx_exp[$];
    logic [63:0] rx_exp[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          wr_cnt = 0;
    int          req_cnt = 0;
    int          poll_cnt = 0;
    int          strobe_cnt = 0;

    nic_pe_driver #(.PKT_W(64), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .num_pkts(num_pkts), .rx_expect(rx_expect),
        .vc_sel(vc_sel), .dir_sel(dir_sel), .hop_mask(hop_mask), .src_id(src_id), .seed(seed),
        .addr(addr), .d_in(d_in), .nicEN(nicEN), .nicWrEn(nicWrEn), .d_out(d_out),
        .rx_valid(rx_valid), .rx_data(rx_data), .tx_count(tx_count), .rx_count(rx_count),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_true(input string tag, input logic cond);
        n_cmp++;
        assert (cond === 1'b1) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed condition %b expected 1", tag, cond);
        end
    endtask

    function automatic logic [63:0] make_pkt(input logic vc, input logic dir, input logic [7:0] hop,
                                             input logic [15:0] src, input logic [31:0] base, input int idx);
        logic [31:0] pay;
        pay = base + 32'(idx);
        return {vc, dir, 6'b0, hop, src, pay};
    endfunction

    // NIC model: read data appears on d_out the cycle after the request.
    always @(posedge clk) begin
        if (nicEN && !nicWrEn) begin
            case (addr)
                2'b11: d_out <= {63'b0, out_full};
                2'b01: d_out <= {63'b0, (nic_in.size() != 0)};
                2'b00: d_out <= (nic_in.size() != 0) ? nic_in.pop_front() : 64'h0;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (nicEN) req_cnt++;
            if (nicEN && !nicWrEn && addr == 2'b01) poll_cnt++;
            if (nicEN && nicWrEn) begin
                wr_cnt++;
                check_output("wr_addr", 64'(addr), 64'd2);
                check_true("wr_expected", tx_exp.size() != 0);
                if (tx_exp.size() != 0) check_output("wr_data", d_in, tx_exp.pop_front());
            end
            if (rx_valid) begin
                strobe_cnt++;
                check_true("rx_expected", rx_exp.size() != 0);
                if (rx_exp.size() != 0) check_output("rx_data", rx_data, rx_exp.pop_front());
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [7:0] n, input logic [7:0] rxe, input logic vc, input logic dir,
                                  input logic [7:0] hop, input logic [15:0] src, input logic [31:0] sd);
        tick();
        num_pkts  = n;
        rx_expect = rxe;
        vc_sel    = vc;
        dir_sel   = dir;
        hop_mask  = hop;
        src_id    = src;
        seed      = sd;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check_output(tag, 64'(done), 64'd1);
    endtask

    initial begin
        int w0, r0, p0, s0, k;
        logic seen;

        rst = 1'b0;
        #1;
        $display("[TB] reset phase");
        check_output("rst_nic", {addr, nicEN, nicWrEn, d_in}, 68'h0);
        check_output("rst_rx", {rx_valid, rx_data}, 65'h0);
        check_output("rst_cnt", {tx_count, rx_count, busy, done}, 18'h0);
        tick();
        rst = 1'b1;
        tick();
        check_output("idle_busy", 64'(busy), 64'd0);

        // Empty job: DONE three cycles after start with no NIC traffic
        r0 = req_cnt;
        apply_stimulus(8'd0, 8'd0, 1'b0, 1'b0, 8'h00, 16'h0, 32'h0);
        check_output("zero_busy", 64'(busy), 64'd1);
        tick();
        check_output("zero_done_early", 64'(done), 64'd0);
        tick();
        check_output("zero_done", 64'(done), 64'd1);
        check_output("zero_reqs", 64'(req_cnt - r0), 64'd0);

        // Single inject, started from DONE
        w0 = wr_cnt;
        tx_exp.push_back(64'h40ff_0000_ffff_fff1);
        apply_stimulus(8'd1, 8'd0, 1'b0, 1'b1, 8'hff, 16'h0000, 32'hffff_fff1);
        wait_done("single_done", 50);
        check_output("single_tx_count", 64'(tx_count), 64'd1);
        check_output("single_writes", 64'(wr_cnt - w0), 64'd1);

        // Backpressure: full output buffer, receive polling continues, late start ignored
        out_full = 1'b1;
        w0 = wr_cnt;
        p0 = poll_cnt;
        tx_exp.push_back(make_pkt(1'b1, 1'b0, 8'h0f, 16'hbeef, 32'h1234_0000, 0));
        apply_stimulus(8'd1, 8'd1, 1'b1, 1'b0, 8'h0f, 16'hbeef, 32'h1234_0000);
        tick();
        num_pkts = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        num_pkts = 8'd1;
        for (int i = 0; i < 18; i++) tick();
        check_output("bp_no_writes", 64'(wr_cnt - w0), 64'd0);
        check_true("bp_polls", (poll_cnt - p0) > 2);
        out_full = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            tick();
            seen = nicEN && nicWrEn;
        end
        check_true("bp_write_within_6", seen);
        rx_exp.push_back(64'h0123_4567_89ab_cdef);
        nic_in.push_back(64'h0123_4567_89ab_cdef);
        wait_done("bp_done", 100);
        check_output("bp_counts", {tx_count, rx_count}, {8'd1, 8'd1});

        // Receive two packets; a third stays in the NIC
        s0 = strobe_cnt;
        rx_exp.push_back(64'h80ff_0000_ffff_0002);
        rx_exp.push_back(64'hc0ff_0000_ffff_0003);
        nic_in.push_back(64'h80ff_0000_ffff_0002);
        nic_in.push_back(64'hc0ff_0000_ffff_0003);
        nic_in.push_back(64'hdead_beef_0000_0001);
        apply_stimulus(8'd0, 8'd2, 1'b0, 1'b0, 8'h00, 16'h0, 32'h0);
        wait_done("rx_done", 100);
        check_output("rx_count", 64'(rx_count), 64'd2);
        check_output("rx_strobes", 64'(strobe_cnt - s0), 64'd2);
        check_output("rx_last", rx_data, 64'hc0ff_0000_ffff_0003);
        check_output("rx_left_in_nic", 64'(nic_in.size()), 64'd1);
        nic_in.delete();

        // Payload wraps modulo 2^32
        tx_exp.push_back(64'h0000_00a5_ffff_ffff);
        tx_exp.push_back(64'h0000_00a5_0000_0000);
        apply_stimulus(8'd2, 8'd0, 1'b0, 1'b0, 8'h00, 16'h00a5, 32'hffff_ffff);
        wait_done("wrap_done", 100);
        check_output("wrap_tx_count", 64'(tx_count), 64'd2);

        // Reset in the middle of a four-packet burst, then rerun from scratch
        w0 = wr_cnt;
        for (int i = 0; i < 4; i++) tx_exp.push_back(make_pkt(1'b1, 1'b1, 8'h3c, 16'h7777, 32'h0000_1000, i));
        apply_stimulus(8'd4, 8'd0, 1'b1, 1'b1, 8'h3c, 16'h7777, 32'h0000_1000);
        k = 0;
        while ((wr_cnt - w0) < 2 && k < 100) begin
            tick();
            k++;
        end
        check_output("mid_two_writes", 64'(wr_cnt - w0), 64'd2);
        rst = 1'b0;
        #1;
        check_output("mid_rst_nicen", 64'(nicEN), 64'd0);
        check_output("mid_rst_counts", {tx_count, rx_count, busy}, 17'h0);
        tx_exp.delete();
        tick();
        rst = 1'b1;
        w0 = wr_cnt;
        for (int i = 0; i < 4; i++) tx_exp.push_back(make_pkt(1'b1, 1'b1, 8'h3c, 16'h7777, 32'h0000_1000, i));
        apply_stimulus(8'd4, 8'd0, 1'b1, 1'b1, 8'h3c, 16'h7777, 32'h0000_1000);
        wait_done("rerun_done", 200);
        check_output("rerun_writes", 64'(wr_cnt - w0), 64'd4);
        check_output("rerun_tx_count", 64'(tx_count), 64'd4);

        tick();
        check_output("tx_queue_empty", 64'(tx_exp.size()), 64'd0);
        check_output("rx_queue_empty", 64'(rx_exp.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
